signed_mult_ctrl: RTL and testbench

- Sequencing controller for the lab's signed multiply path. Accepts two signed two's-complement operands under a start/done handshake.
- Converts each operand to magnitude and records the result sign, then runs an iterative shift-add unsigned multiply.
- Applies the sign to the product and presents a registered signed result.
- Sits between the test/top-level operand source and the downstream product consumer. Owns all sequencing of the magnitude-conversion and shift-add datapath.

---
 rtl/signed_mult_ctrl.sv | 122 ++++++++++++
 tb/tb_signed_mult_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/signed_mult_ctrl.sv
// Signed multiply sequencer: magnitude conversion, WIDTH-cycle shift-add, sign fix-up.
// Optional SIGNED_MULT_ZERO_SKIP_EN: a zero operand bypasses the shift-add loop.
module signed_mult_ctrl #(
  parameter int WIDTH = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic [WIDTH-1:0]   x_in,
  input  logic [WIDTH-1:0]   y_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product_out
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CONVERT, MULT, SIGN} state_t;

  state_t          state_reg, state_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic [PW-1:0]    mcand_reg, mcand_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [PW-1:0]    acc_reg, acc_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             neg_reg, neg_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [PW-1:0]    product_reg, product_next;

  // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
  logic [WIDTH-1:0] mag_x, mag_y;
  assign mag_x = x_reg[WIDTH-1] ? (~x_reg + WIDTH'(1)) : x_reg;
  assign mag_y = y_reg[WIDTH-1] ? (~y_reg + WIDTH'(1)) : y_reg;

  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    count_next   = count_reg;
    neg_next     = neg_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    product_next = product_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          x_next     = x_in;
          y_next     = y_in;
          busy_next  = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        mcand_next  = {{WIDTH{1'b0}}, mag_x};
        mplier_next = mag_y;
        neg_next    = x_reg[WIDTH-1] ^ y_reg[WIDTH-1];
        acc_next    = '0;
        count_next  = '0;
        state_next  = MULT;
`ifdef SIGNED_MULT_ZERO_SKIP_EN
        if (mag_x == '0 || mag_y == '0) state_next = SIGN;
`endif
      end
      MULT: begin
        if (mplier_reg[0]) acc_next = acc_reg + mcand_reg;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg + CW'(1);
        if (count_reg == CW'(WIDTH - 1)) state_next = SIGN;
      end
      SIGN: begin
        // Negating a zero accumulator yields zero, so the product is never -0.
        product_next = neg_reg ? (~acc_reg + PW'(1)) : acc_reg;
        done_next    = 1'b1;
        busy_next    = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      neg_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      product_reg <= '0;
    end else if (enable) begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      acc_reg     <= acc_next;
      count_reg   <= count_next;
      neg_reg     <= neg_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      product_reg <= product_next;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign product_out = product_reg;

endmodule

// File: tb/tb_signed_mult_ctrl.sv
// Directed bench for signed_mult_ctrl (WIDTH=12): signs, extremes, handshake, stall, reset.
module tb_signed_mult_ctrl;

  localparam int W = 12;
`ifdef SIGNED_MULT_ZERO_SKIP_EN
  localparam int ZERO_LAT = 2;
`else
  localparam int ZERO_LAT = 14;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          enable = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  x_in = '0;
  logic [W-1:0]  y_in = '0;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product_out;

  int n_checks = 0;
  int n_fail   = 0;

  signed_mult_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .x_in        (x_in),
    .y_in        (y_in),
    .busy        (busy),
    .done        (done),
    .product_out (product_out)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts edges until done is seen; optionally stalls or pulses a stray start mid-run.
  task automatic wait_done(input int stall_at, input int stall_len, input int ign_at,
                           output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (lat == ign_at) begin
        x_in = 12'h123; y_in = 12'h456; start = 1'b1;
      end else if (lat == ign_at + 1) begin
        start = 1'b0;
      end
      if (lat == stall_at) begin
        enable = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          lat++;
          if (!busy || done) busy_ok = 1'b0;
        end
        enable = 1'b1;
      end
    end
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2*W-1:0] exp_p,
                       input int exp_lat, input string tag,
                       input int stall_at, input int stall_len, input int ign_at);
    int lat;
    bit bok;
    @(negedge clk);
    x_in = x; y_in = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_value({tag, "_busy_acc"}, busy, 1);
    wait_done(stall_at, stall_len, ign_at, lat, bok);
    check_value({tag, "_lat"}, lat, exp_lat);
    check_value({tag, "_busy_run"}, bok, 1);
    check_value({tag, "_prod"}, product_out, exp_p);
    check_value({tag, "_busy_done"}, busy, 0);
    $display("op %s: x=0x%h y=0x%h product=0x%h latency=%0d", tag, x, y, product_out, lat);
  endtask

  task automatic expect_quiet(input int n, input string tag);
    int events;
    events = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done || busy) events++;
    end
    check_value(tag, events, 0);
  endtask

  initial begin
    int lat;
    bit bok;

    reset = 1'b1;
    #2 reset = 1'b0;
    #10;
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    check_value("rst_prod", product_out, 0);
    @(negedge clk); reset = 1'b1;

    do_op(12'd3,   12'd5,   24'h00000F, 14, "pos_pos", -1, 0, -1);
    do_op(12'hFFD, 12'd5,   24'hFFFFF1, 14, "neg_pos", -1, 0, -1);
    do_op(12'hFFD, 12'hFFB, 24'h00000F, 14, "neg_neg", -1, 0, -1);
    do_op(12'h800, 12'h800, 24'h400000, 14, "min_min", -1, 0, -1);
    do_op(12'h7FF, 12'h800, 24'hC00800, 14, "max_min", -1, 0, -1);

    // done must stretch across a stall and clear on the next enabled edge
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("stretch_done", done, 1);
    check_value("stretch_prod", product_out, 24'hC00800);
    enable = 1'b1;
    @(posedge clk); #1;
    check_value("stretch_clear", done, 0);

    do_op(12'd0,   12'hFF9, 24'h000000, ZERO_LAT, "zero", -1, 0, -1);
    do_op(12'd100, 12'hFFE, 24'hFFFF38, 18, "stall", 4, 4, -1);
    do_op(12'd6,   12'd7,   24'h00002A, 14, "ignore", -1, 0, 5);
    expect_quiet(20, "ignore_no_extra");

    // Back-to-back: start held high, second operands presented while busy
    @(negedge clk);
    x_in = 12'd7; y_in = 12'd3; start = 1'b1;
    @(posedge clk); #1;
    x_in = 12'd2; y_in = 12'hFFF;
    wait_done(-1, 0, -1, lat, bok);
    check_value("b2b_a_lat", lat, 14);
    check_value("b2b_a_prod", product_out, 24'h000015);
    $display("op b2b_a: product=0x%h latency=%0d", product_out, lat);
    @(posedge clk); #1;
    start = 1'b0;
    check_value("b2b_accept_done", done, 0);
    check_value("b2b_accept_busy", busy, 1);
    wait_done(-1, 0, -1, lat, bok);
    check_value("b2b_b_lat", lat, 14);
    check_value("b2b_b_prod", product_out, 24'hFFFFFE);
    $display("op b2b_b: product=0x%h latency=%0d", product_out, lat);

    // Asynchronous reset in the middle of MULT
    @(negedge clk);
    x_in = 12'd5; y_in = 12'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_value("mid_rst_busy", busy, 0);
    check_value("mid_rst_done", done, 0);
    check_value("mid_rst_prod", product_out, 0);
    $display("op mid_reset: busy=%0d done=%0d product=0x%h", busy, done, product_out);
    @(negedge clk); reset = 1'b1;
    expect_quiet(20, "post_rst_quiet");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
